candy_if_prefetch: RTL
======================

Name: candy_if_prefetch

Overview:
Parametrised next-generation instruction fetch unit. It fetches sequentially from SRAM ahead of the decoder and buffers {pc, inst} pairs in a DEPTH-entry prefetch FIFO. It presents instructions to decode via a valid/ready handshake and supports redirect (branch/jump) with flush and discard of any in-flight read. It sits between the PC/branch logic and the SRAM port, where the single-register fetch stage was.

Parameters:
ADDR_W, 17, SRAM address width and PC width
DATA_W, 24, SRAM data / instruction width
DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
PC_STEP, 1, fetch PC increment per instruction
RESET_PC, 0, fetch PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
if_enable  in  1  1 = fetching allowed; 0 = no new SRAM requests (an in-flight request still completes)
redirect  in  1  1-cycle pulse: flush FIFO, restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1
sram_read_enable  out  1  SRAM read request, registered
sram_addr  out  ADDR_W  SRAM read address, registered
data_ready  in  1  SRAM: sram_data valid for current request this cycle
sram_data  in  DATA_W  SRAM read data
inst  out  DATA_W  FIFO head instruction
inst_pc  out  ADDR_W  address of inst
inst_valid  out  1  FIFO non-empty
inst_ready  in  1  decoder accepts head; pop when inst_valid & inst_ready

Behaviour:
- Reset (rst=0, async): state=IDLE, fetch_pc=RESET_PC, sram_read_enable=0, sram_addr=0, FIFO count=0, rd/wr pointers=0, inst_valid=0. inst and inst_pc read 0 (storage cleared or output-gated).
- SRAM protocol: when sram_read_enable=1, sram_addr is held stable until the cycle data_ready=1. That cycle completes the request. At most one request is outstanding. A request is never withdrawn before data_ready.
- pop = inst_valid & inst_ready & ~redirect. count_next = count + push - pop.
- may_issue = if_enable & ~redirect & (count_next < DEPTH).
- FSM states and transitions:
  - IDLE: sram_read_enable=0. If may_issue: sram_addr<=fetch_pc, sram_read_enable<=1, go REQ.
  - REQ, no data_ready, no redirect: hold.
  - REQ, data_ready=1, redirect=0: push {sram_addr, sram_data}, fetch_pc<=fetch_pc+PC_STEP. If may_issue: sram_addr<=fetch_pc+PC_STEP, stay REQ (back-to-back, one inst/cycle max). Else sram_read_enable<=0, go IDLE.
  - REQ, redirect=1, data_ready=0: go DISCARD, keep request asserted.
  - REQ, redirect=1, data_ready=1: drop data, sram_read_enable<=0, go IDLE.
  - DISCARD: request held. On data_ready: data dropped, sram_read_enable<=0, go IDLE. Never pushes.
- Redirect (any state): FIFO count/pointers <= 0, fetch_pc <= redirect_pc. A later redirect overrides an earlier one, including while in DISCARD. No request is issued in a redirect cycle. The first read of redirect_pc is asserted at the 2nd rising edge after redirect, or later if DISCARD is pending.
- Push and pop in the same cycle with FIFO full: allowed, because may_issue accounts for the pop. The FIFO never overflows; a push into a full FIFO is a design error (assertion).
- fetch_pc and sram_addr wrap modulo 2^ADDR_W (e.g. 0x1FFFF+1 -> 0x00000 at ADDR_W=17).
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Latency: with data_ready=1 on the first request cycle, inst_valid rises the edge after that cycle.
- Reset asserted mid-request: sram_read_enable drops immediately (async), and any pending data is ignored.

Test Plan:
- Reset then if_enable=1, data_ready tied 1, inst_ready=1 -> sram_addr 0,1,2,3… on consecutive cycles; inst_pc/inst stream matches, one per cycle, no gaps.
- inst_ready=0, data_ready=1, DEPTH=4 -> exactly 4 pushes (addr 0..3), then sram_read_enable=0 and inst_valid=1 held. Raise inst_ready -> fetch resumes at addr 4 with no duplicate or lost entry.
- data_ready delayed 3 cycles per request -> sram_addr/sram_read_enable stable across wait cycles; FIFO order preserved.
- Redirect to 0x00100 while a request to addr 5 is outstanding (data_ready 2 cycles later) -> inst_valid=0 next cycle, addr-5 data never appears, next request addr 0x00100, first inst_pc=0x00100.
- Redirect to 0x1FFFF -> fetched pcs 0x1FFFF, 0x00000, 0x00001 (wrap).
- rst pulsed low mid-REQ with 2 FIFO entries -> sram_read_enable=0, inst_valid=0 asynchronously; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/candy_if_prefetch.sv
// Instruction fetch unit: sequential SRAM prefetch into a DEPTH-entry {pc, inst} FIFO,
// valid/ready hand-off to decode, and redirect with flush and discard of an in-flight read.
module candy_if_prefetch #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 24,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_enable,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              sram_read_enable,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] sram_data,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              re_q, re_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];

    logic              fifo_valid;
    logic              push;
    logic              pop;
    logic              may_issue;
    logic [ADDR_W-1:0] pc_inc;

    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid & inst_ready & ~redirect;
    assign push       = (state_q == S_REQ) & data_ready & ~redirect;
    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);
    // Room is judged after this cycle's push and pop, so a full FIFO that pops can still refill.
    assign may_issue  = if_enable & ~redirect & (count_next < DEPTH_C);
    assign pc_inc     = fetch_pc_q + STEP_C;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        re_d       = re_q;
        case (state_q)
            S_IDLE: begin
                if (may_issue) begin
                    addr_d  = fetch_pc_q;
                    re_d    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    if (data_ready) begin
                        re_d    = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end else if (data_ready) begin
                    fetch_pc_d = pc_inc;
                    if (may_issue) begin
                        addr_d = pc_inc;
                    end else begin
                        re_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                // The stale request must still complete before the port can be reused.
                if (data_ready) begin
                    re_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                re_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_comb begin
        count_d  = count_next;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC_C;
            addr_q     <= '0;
            re_q       <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            re_q       <= re_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= addr_q;
            inst_mem_q[wr_ptr_q] <= sram_data;
        end
    end

    // Storage is not reset; the head is gated so an empty FIFO always presents zeros.
    assign inst_valid       = fifo_valid;
    assign inst             = fifo_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign inst_pc          = fifo_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign sram_read_enable = re_q;
    assign sram_addr        = addr_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        (push && !pop) |-> (count_q < DEPTH_C));

endmodule
